vga_scan: RTL



---
 rtl/vga_pkg.sv | 35 +++
 rtl/vga_delay_line.sv | 33 +++
 rtl/vga_scan.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared timing defaults, colour struct and read-data unpacking for vga_scan.
package vga_pkg;

    // 640x480@60 reference timing
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_COLOR_W  = 4;

    // Widest colour channel the unpack helper can carry
    localparam int MAX_COLOR_W  = 8;

    typedef struct packed {
        logic [MAX_COLOR_W-1:0] R;
        logic [MAX_COLOR_W-1:0] G;
        logic [MAX_COLOR_W-1:0] B;
    } rgb_t;

    // Split q[3*cw-1:0] = {R,G,B}; each field lands right-aligned in its slot
    function automatic rgb_t unpack_q(input logic [31:0] qd, input int cw);
        logic [31:0] m;
        rgb_t        c;
        m   = (32'd1 << cw) - 32'd1;
        c.B = MAX_COLOR_W'(qd & m);
        c.G = MAX_COLOR_W'((qd >> cw) & m);
        c.R = MAX_COLOR_W'((qd >> (2 * cw)) & m);
        return c;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: reset-clearable shift register aligning the timing bundle
// with the framebuffer read latency. DEPTH=0 is a plain wire.
module vga_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_d
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused;
            assign w_unused = clock ^ reset;
            assign o_d      = i_d;
        end else begin : g_sr
            logic [DEPTH-1:0][WIDTH-1:0] r_sr;
            // shift one stage per clock; reset empties every stage at once
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_sr <= '0;
                end else begin
                    r_sr[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
                end
            end
            assign o_d = r_sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_scan.sv
// vga_scan: parametrised VGA timing/scan engine. Counts h/v, issues framebuffer
// reads in the active area and drives registered RGB/sync pins RD_LAT+1 cycles
// after the counter state. Optional colour-bar generator under VGA_TEST_PATTERN_EN.
module vga_scan
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int COLOR_W  = DEF_COLOR_W,
    parameter int PIX_W    = 16,
    parameter int RD_LAT   = 1,
    parameter int ADDR_W   = 19
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
`ifdef VGA_TEST_PATTERN_EN
    input  logic               pattern_sel,
`endif
    output logic [ADDR_W-1:0]  rd_addr,
    output logic               rd_en,
    input  logic [PIX_W-1:0]   q,
    output logic               HS,
    output logic               VS,
    output logic [COLOR_W-1:0] VGA_R,
    output logic [COLOR_W-1:0] VGA_G,
    output logic [COLOR_W-1:0] VGA_B,
    output logic               frame_start,
    output logic               line_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // one spare code so the sync-end constant never aliases to 0
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] C_H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] C_HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] C_HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] C_H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] C_V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] C_VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] C_VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] C_V_LAST = VW'(V_TOTAL - 1);

    localparam logic HS_IDLE = (HS_POL == 0);
    localparam logic VS_IDLE = (VS_POL == 0);

`ifdef VGA_TEST_PATTERN_EN
    localparam int BW = 9;   // {psel, bar[2:0], de, hs, vs, fs, ls}
`else
    localparam int BW = 5;   // {de, hs, vs, fs, ls}
`endif

    logic [HW-1:0]     r_h;
    logic [VW-1:0]     r_v;
    logic [ADDR_W-1:0] r_addr;
    logic              w_de, w_hs_act, w_vs_act, w_fs, w_ls;
    logic [BW-1:0]     w_bin, w_bout;
    logic              w_d_de, w_d_hs, w_d_vs, w_d_fs, w_d_ls;
    rgb_t              w_col;
    logic              w_unused_col;
    logic [COLOR_W-1:0] w_pix_r, w_pix_g, w_pix_b;

    logic               r_hs, r_vs, r_fs, r_ls;
    logic [COLOR_W-1:0] r_r, r_g, r_b;

    assign w_de     = (r_h < C_H_ACT) && (r_v < C_V_ACT);
    assign w_hs_act = (r_h >= C_HS_BEG) && (r_h < C_HS_END);
    assign w_vs_act = (r_v >= C_VS_BEG) && (r_v < C_VS_END);
    assign w_fs     = (r_h == '0) && (r_v == '0);
    assign w_ls     = (r_h == '0) && (r_v < C_V_ACT);

    // read strobe is suppressed while reset or disable hold the counters
    assign rd_en   = w_de && enable && !reset;
    assign rd_addr = r_addr;

    // h/v raster counters; disable parks them at the frame origin
    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == C_H_LAST) begin
            r_h <= '0;
            r_v <= (r_v == C_V_LAST) ? '0 : r_v + VW'(1);
        end else begin
            r_h <= r_h + HW'(1);
        end
    end

    // linear read address: steps after each active pixel, cleared at frame wrap
    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            r_addr <= '0;
        end else if ((r_h == C_H_LAST) && (r_v == C_V_LAST)) begin
            r_addr <= '0;
        end else if (w_de) begin
            r_addr <= r_addr + ADDR_W'(1);
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int PCW   = $clog2(BAR_W + 1);
    localparam logic [PCW-1:0] C_BAR_LAST = PCW'(BAR_W - 1);

    logic [PCW-1:0] r_pcnt;
    logic [2:0]     r_bar;
    logic           w_d_psel;
    logic [2:0]     w_d_bar;

    // bar index tracks h: advances every BAR_W active pixels, zero at line start
    always_ff @(posedge clock) begin
        if (reset || !enable || (r_h == C_H_LAST)) begin
            r_pcnt <= '0;
            r_bar  <= '0;
        end else if (r_h < C_H_ACT) begin
            if (r_pcnt == C_BAR_LAST) begin
                r_pcnt <= '0;
                r_bar  <= r_bar + 3'd1;
            end else begin
                r_pcnt <= r_pcnt + PCW'(1);
            end
        end
    end

    assign w_bin[8:5] = {pattern_sel, r_bar};
    assign w_d_psel   = w_bout[8];
    assign w_d_bar    = w_bout[7:5];
`endif

    // while disabled the pipeline is fed blank, inactive-sync pixels
    assign w_bin[4:0] = enable ? {w_de, w_hs_act, w_vs_act, w_fs, w_ls} : 5'b0;

    vga_delay_line #(
        .DEPTH(RD_LAT),
        .WIDTH(BW)
    ) u_dly (
        .clock(clock),
        .reset(reset),
        .i_d  (w_bin),
        .o_d  (w_bout)
    );

    assign {w_d_de, w_d_hs, w_d_vs, w_d_fs, w_d_ls} = w_bout[4:0];

    assign w_col        = unpack_q(32'(q), COLOR_W);
    assign w_unused_col = ^w_col;

    // colour source: framebuffer word, or the bar generator when selected
    always_comb begin
        w_pix_r = w_col.R[COLOR_W-1:0];
        w_pix_g = w_col.G[COLOR_W-1:0];
        w_pix_b = w_col.B[COLOR_W-1:0];
`ifdef VGA_TEST_PATTERN_EN
        if (w_d_psel) begin
            w_pix_r = {COLOR_W{w_d_bar[2]}};
            w_pix_g = {COLOR_W{w_d_bar[1]}};
            w_pix_b = {COLOR_W{w_d_bar[0]}};
        end
`endif
    end

    // pin register: blanks colour outside de and applies sync polarity
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hs <= HS_IDLE;
            r_vs <= VS_IDLE;
            r_r  <= '0;
            r_g  <= '0;
            r_b  <= '0;
            r_fs <= 1'b0;
            r_ls <= 1'b0;
        end else begin
            r_hs <= w_d_hs ^ HS_IDLE;
            r_vs <= w_d_vs ^ VS_IDLE;
            r_r  <= w_d_de ? w_pix_r : '0;
            r_g  <= w_d_de ? w_pix_g : '0;
            r_b  <= w_d_de ? w_pix_b : '0;
            r_fs <= w_d_fs;
            r_ls <= w_d_ls;
        end
    end

    assign HS          = r_hs;
    assign VS          = r_vs;
    assign VGA_R       = r_r;
    assign VGA_G       = r_g;
    assign VGA_B       = r_b;
    assign frame_start = r_fs;
    assign line_start  = r_ls;

endmodule
